and3_share_arbiter: RTL and testbench
=====================================

// Module: and3_share_arbiter
// PURPOSE
//  Round-robin controller sharing one gate-level 3-input AND unit among three requesters.
//  Latches the winning requester's operands, drives the shared gate, waits a programmable
//  settle time, then samples its output. Returns the result with a one-cycle DONE pulse.
//  Checks the sampled value against the expected AND and flags MISMATCH for gate-level debug.
// PARAMETERS
//  EVAL_CYCLES  2  cycles shared gate inputs are held before AND_Y is sampled; legal 1..15
// PORTS
//  CLK       input   1  clock, rising edge
//  RST_N     input   1  reset, asynchronous, active-low
//  REQ       input   3  request, one bit per requester i (level, held until DONE[i])
//  OPS       input   9  operands; OPS[3i+2:3i] = {C,B,A} for requester i, sampled at grant
//  GNT       output  3  one-hot grant, high from grant through DONE cycle
//  AND_A     output  1  shared gate input A
//  AND_B     output  1  shared gate input B
//  AND_C     output  1  shared gate input C
//  AND_Y     input   1  shared gate output
//  DONE      output  3  one-cycle completion pulse to the granted requester
//  RES       output  1  sampled AND_Y; valid while DONE!=0, holds until next capture
//  MISMATCH  output  1  pulses with DONE when RES != &operands
//  BUSY      output  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (RST_N=0, any time, async): state=IDLE, PTR=0, GNT=000, DONE=000, RES=0,
//   MISMATCH=0, BUSY=0, AND_A/B/C=0, operand latch=000, counter=0.
//  FSM states: IDLE, EVAL, RESP.
//  IDLE: AND_A/B/C=0, GNT=000. On an edge with REQ!=0, pick the winner W.
//   Search order is PTR, PTR+1, PTR+2 (mod 3), first set bit wins.
//   Latch OPS[3W+2:3W], set GNT[W], counter=EVAL_CYCLES-1, go to EVAL.
//   REQ=000 stays in IDLE.
//  EVAL: AND_A/B/C driven from the latch (registered outputs, stable the whole state).
//   Counter decrements each edge. On the edge with counter==0: RES<=AND_Y,
//   MISMATCH<=(AND_Y != &latch), DONE[W]<=1, go to RESP.
//  RESP: DONE[W]=1 for exactly this cycle, GNT still =W, AND_* still driven.
//   Next edge: DONE=000, MISMATCH=0, GNT=000, PTR=(W+1) mod 3, go to IDLE.
//  Latency: REQ sampled at edge 0 -> GNT after edge 0 -> DONE high after edge EVAL_CYCLES
//   -> back to IDLE after edge EVAL_CYCLES+1; one transaction per EVAL_CYCLES+2 cycles minimum.
//  Changes to REQ or OPS while BUSY are ignored; a dropped request still completes.
//  A REQ[W] still high in the IDLE cycle after RESP is a new request, arbitrated by round robin.
//  Simultaneous requests: only the winner is served; losers wait with no loss.
//   Under continuous requests each requester waits at most two other transactions.
//  PTR wrap: 2 -> 0. GNT and DONE are never multi-hot. DONE is never high outside RESP.
//  Reset asserted mid-EVAL/RESP: the transaction is aborted, no DONE is issued, and PTR
//   returns to 0. The requester must re-request.
// TESTING
//  1 RST_N=0 with REQ=111 -> GNT=000, DONE=000, RES=0, BUSY=0, AND_A/B/C=0.
//  2 EVAL_CYCLES=2, REQ=001, OPS[2:0]=111, gate model Y=A&B&C -> GNT=001 after edge 0,
//    AND_A/B/C=1. DONE=001 and RES=1 in the cycle after edge 2, MISMATCH=0.
//    BUSY=0 after edge 3.
//  3 REQ=111 held, OPS=9'b111_011_111 -> grant order 001,010,100,001.
//    RES sequence 1,0,1,1.
//  4 REQ=010, OPS[5:3]=101 -> AND_A=1, AND_B=0, AND_C=1; DONE=010, RES=0, MISMATCH=0.
//  5 Gate model stuck-at-0, REQ=100, OPS[8:6]=111 -> DONE=100, RES=0, MISMATCH=1 for one cycle.
//  6 RST_N pulsed low during EVAL of requester 2 -> no DONE, reset values.
//    After release, REQ=110 -> GNT=010 (PTR=0, first set bit from 0 is 1).

Source files
------------

// File: rtl/and3_share_arbiter.sv
// ============================================================================
// Module   : and3_share_arbiter
// Purpose  : Round-robin sharing of one external 3-input AND gate among three
//            requesters, with result capture and expected-value mismatch flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module and3_share_arbiter #(
    parameter int EVAL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_req,
    input  logic [8:0] i_ops,
    output logic [2:0] o_gnt,
    output logic       o_and_a,
    output logic       o_and_b,
    output logic       o_and_c,
    input  logic       i_and_y,
    output logic [2:0] o_done,
    output logic       o_res,
    output logic       o_mismatch,
    output logic       o_busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EVAL = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [3:0] c_CNT_LOAD = 4'(EVAL_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_win;
    logic [2:0] r_gnt;
    logic [2:0] r_lat;
    logic [3:0] r_cnt;
    logic [2:0] r_done;
    logic       r_res;
    logic       r_mis;

    logic [1:0] w_win;
    logic [2:0] w_ops;

    // First set request bit at or after the pointer, wrapping 2 -> 0.
    always_comb begin
        w_win = 2'd0;
        case (r_ptr)
            2'd1:    w_win = i_req[1] ? 2'd1 : (i_req[2] ? 2'd2 : 2'd0);
            2'd2:    w_win = i_req[2] ? 2'd2 : (i_req[0] ? 2'd0 : 2'd1);
            default: w_win = i_req[0] ? 2'd0 : (i_req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_ops = i_ops[2:0];
        case (w_win)
            2'd1:    w_ops = i_ops[5:3];
            2'd2:    w_ops = i_ops[8:6];
            default: w_ops = i_ops[2:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ptr   <= 2'd0;
            r_win   <= 2'd0;
            r_gnt   <= 3'b000;
            r_lat   <= 3'b000;
            r_cnt   <= 4'd0;
            r_done  <= 3'b000;
            r_res   <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_req != 3'b000) begin
                        r_win   <= w_win;
                        r_gnt   <= 3'b001 << w_win;
                        r_lat   <= w_ops;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= c_EVAL;
                    end
                end
                c_EVAL: begin
                    if (r_cnt == 4'd0) begin
                        r_res   <= i_and_y;
                        r_mis   <= (i_and_y != (&r_lat));
                        r_done  <= r_gnt;
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    // Gate inputs return to zero with the latch so IDLE drives 000.
                    r_done  <= 3'b000;
                    r_mis   <= 1'b0;
                    r_gnt   <= 3'b000;
                    r_lat   <= 3'b000;
                    r_ptr   <= (r_win == 2'd2) ? 2'd0 : r_win + 2'd1;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_and_a    = r_lat[0];
    assign o_and_b    = r_lat[1];
    assign o_and_c    = r_lat[2];
    assign o_done     = r_done;
    assign o_res      = r_res;
    assign o_mismatch = r_mis;
    assign o_busy     = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_and3_share_arbiter.sv
// ============================================================================
// Module   : tb_and3_share_arbiter
// Purpose  : Directed plus randomized transaction checks of and3_share_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and3_share_arbiter;

    localparam int EVAL = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] i_req;
    logic [8:0] i_ops;
    logic [2:0] o_gnt;
    logic       o_and_a;
    logic       o_and_b;
    logic       o_and_c;
    logic       i_and_y;
    logic [2:0] o_done;
    logic       o_res;
    logic       o_mismatch;
    logic       o_busy;
    logic       stuck;

    int total = 0;
    int bad   = 0;
    int ptr   = 0;

    and3_share_arbiter #(.EVAL_CYCLES(EVAL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_ops      (i_ops),
        .o_gnt      (o_gnt),
        .o_and_a    (o_and_a),
        .o_and_b    (o_and_b),
        .o_and_c    (o_and_c),
        .i_and_y    (i_and_y),
        .o_done     (o_done),
        .o_res      (o_res),
        .o_mismatch (o_mismatch),
        .o_busy     (o_busy)
    );

    // Gate model: true AND, or stuck-at-0 when requested.
    assign i_and_y = stuck ? 1'b0 : (o_and_a & o_and_b & o_and_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_winner(input logic [2:0] req, input int p);
        for (int k = 0; k < 3; k++) begin
            if (req[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic txn(input logic [2:0] req, input logic [8:0] ops,
                       input bit stk, input bit jitter, output logic res_o);
        int          w;
        logic [2:0]  wops;
        logic        exp_res;
        w       = rr_winner(req, ptr);
        wops    = ops[3*w +: 3];
        exp_res = stk ? 1'b0 : (&wops);
        i_req = req;
        i_ops = ops;
        stuck = stk;
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
        step();
        chk("gnt", {29'd0, o_gnt}, 32'(3'b001 << w));
        chk("and_abc", {29'd0, o_and_c, o_and_b, o_and_a}, {29'd0, wops});
        chk("busy", {31'd0, o_busy}, 32'd1);
        if (jitter) begin
            i_req = 3'($urandom);
            i_ops = 9'($urandom);
        end
        for (int c = 1; c < EVAL; c++) begin
            chk("done_early", {29'd0, o_done}, 32'd0);
            step();
        end
        step();
        chk("done", {29'd0, o_done}, 32'(3'b001 << w));
        chk("res", {31'd0, o_res}, {31'd0, exp_res});
        chk("mismatch", {31'd0, o_mismatch}, {31'd0, exp_res != (&wops)});
        chk("gnt_resp", {29'd0, o_gnt}, 32'(3'b001 << w));
        step();
        chk("done_clr", {29'd0, o_done, o_mismatch, o_busy}, 32'd0);
        chk("gnt_clr", {29'd0, o_gnt}, 32'd0);
        chk("and_clr", {29'd0, o_and_c, o_and_b, o_and_a}, 32'd0);
        ptr   = (w + 1) % 3;
        i_req = 3'b000;
        stuck = 1'b0;
        res_o = o_res;
    endtask

    initial begin
        logic r;
        logic [2:0] rq;
        rst_n = 1'b0;
        i_req = 3'b111;
        i_ops = 9'h1FF;
        stuck = 1'b0;
        step();
        step();
        chk("rst_state", {24'd0, o_gnt, o_done, o_res, o_busy},  32'd0);
        chk("rst_and", {29'd0, o_and_c, o_and_b, o_and_a}, 32'd0);
        rst_n = 1'b1;
        i_req = 3'b000;
        step();

        // Held 111 requests rotate 0,1,2,0 with results 1,0,1,1.
        txn(3'b111, 9'b111_011_111, 1'b0, 1'b0, r); chk("rr_res0", {31'd0, r}, 32'd1);
        txn(3'b111, 9'b111_011_111, 1'b0, 1'b0, r); chk("rr_res1", {31'd0, r}, 32'd0);
        txn(3'b111, 9'b111_011_111, 1'b0, 1'b0, r); chk("rr_res2", {31'd0, r}, 32'd1);
        txn(3'b111, 9'b111_011_111, 1'b0, 1'b0, r); chk("rr_res3", {31'd0, r}, 32'd1);

        txn(3'b001, 9'b000_000_111, 1'b0, 1'b0, r);
        txn(3'b010, 9'b000_101_000, 1'b0, 1'b0, r);
        txn(3'b100, 9'b111_000_000, 1'b1, 1'b0, r);

        for (int n = 0; n < 40; n++) begin
            rq = 3'($urandom_range(1, 7));
            txn(rq, 9'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1, r);
            if ($urandom_range(0, 2) == 0) step();
        end

        // Abort during EVAL: no DONE, pointer back to 0.
        i_req = 3'b100;
        i_ops = 9'b111_000_000;
        step();
        chk("abort_gnt", {29'd0, o_gnt}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rst", {23'd0, o_gnt, o_done, o_mismatch, o_res, o_busy}, 32'd0);
        chk("abort_and", {29'd0, o_and_c, o_and_b, o_and_a}, 32'd0);
        i_req = 3'b000;
        step();
        rst_n = 1'b1;
        ptr = 0;
        step();
        chk("abort_nodone", {29'd0, o_done}, 32'd0);
        txn(3'b110, 9'b111_111_000, 1'b0, 1'b0, r);
        chk("abort_ptr", ptr, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
